// File: rtl/pa_seq_ctrl.sv
// pa_seq_ctrl: multi-channel PA power sequencer behind a valid/ready bus.
// Per channel: CTRL/TARGET/SETTLE/STATUS regs plus a wake/ramp/rampdown FSM.
module pa_seq_ctrl #(
  parameter int DATA_W    = 32,
  parameter int N_CH      = 2,
  parameter int MODE_W    = 2,
  parameter int LVL_W     = 4,
  parameter int STEP_LOG2 = 3,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid,
  input  logic [CH_W+1:0]         address,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    wstrb,
  output logic [DATA_W-1:0]       rdata,
  output logic                    ready,
  output logic [N_CH-1:0]         pd,
  output logic [N_CH*MODE_W-1:0]  mode,
  output logic [N_CH*LVL_W-1:0]   level,
  output logic                    busy
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_WAKE = 3'd1,
    S_RAMP = 3'd2,
    S_ON   = 3'd3,
    S_RDN  = 3'd4
  } st_e;

  logic [CH_W-1:0]      ch;
  logic [1:0]           rsel;
  logic                 ch_ok;
  logic                 acc;
  logic [DATA_W-1:0]    rd_val;

  logic                 en_r   [N_CH];
  logic [MODE_W-1:0]    mode_r [N_CH];
  logic [LVL_W-1:0]     tgt_r  [N_CH];
  logic [7:0]           set_r  [N_CH];

  st_e                  st_q   [N_CH];
  st_e                  st_d   [N_CH];
  logic [LVL_W-1:0]     lvl_q  [N_CH];
  logic [LVL_W-1:0]     lvl_d  [N_CH];
  logic [7:0]           cnt_q  [N_CH];
  logic [7:0]           cnt_d  [N_CH];
  logic [STEP_LOG2-1:0] psc_q  [N_CH];
  logic [STEP_LOG2-1:0] psc_d  [N_CH];

  assign ch    = address[CH_W+1:2];
  assign rsel  = address[1:0];
  assign ch_ok = int'(ch) < N_CH;
  assign acc   = valid && !ready;

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_ok && ch == CH_W'(c)) begin
        unique case (rsel)
          2'd0:    rd_val[MODE_W:0]  = {mode_r[c], en_r[c]};
          2'd1:    rd_val[LVL_W-1:0] = tgt_r[c];
          2'd2:    rd_val[7:0]       = set_r[c];
          default: rd_val[LVL_W+2:0] = {lvl_q[c], st_q[c]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
      rdata <= '0;
      for (int c = 0; c < N_CH; c++) begin
        en_r[c]   <= 1'b0;
        mode_r[c] <= '0;
        tgt_r[c]  <= '0;
        set_r[c]  <= '0;
      end
    end else begin
      ready <= acc;
      rdata <= acc ? rd_val : '0;
      for (int c = 0; c < N_CH; c++) begin
        if (acc && wstrb && ch_ok && ch == CH_W'(c)) begin
          unique case (rsel)
            2'd0: begin
              mode_r[c] <= wdata[MODE_W:1];
              en_r[c]   <= wdata[0];
            end
            2'd1:    tgt_r[c] <= wdata[LVL_W-1:0];
            2'd2:    set_r[c] <= wdata[7:0];
            default: ;
          endcase
        end
      end
    end
  end

  // WAKE lasts max(1,SETTLE) cycles; steps fire when the prescaler wraps
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      st_d[c]  = st_q[c];
      lvl_d[c] = lvl_q[c];
      cnt_d[c] = cnt_q[c];
      unique case (st_q[c])
        S_OFF: begin
          lvl_d[c] = '0;
          if (en_r[c]) begin
            st_d[c]  = S_WAKE;
            cnt_d[c] = set_r[c];
          end
        end
        S_WAKE: begin
          if (!en_r[c])
            st_d[c] = S_OFF;
          else if (cnt_q[c] <= 8'd1)
            st_d[c] = S_RAMP;
          else
            cnt_d[c] = cnt_q[c] - 8'd1;
        end
        S_RAMP: begin
          if (!en_r[c])
            st_d[c] = S_RDN;
          else if (lvl_q[c] == tgt_r[c])
            st_d[c] = S_ON;
          else if (&psc_q[c])
            lvl_d[c] = (lvl_q[c] < tgt_r[c]) ? lvl_q[c] + 1'b1
                                             : lvl_q[c] - 1'b1;
        end
        S_ON: begin
          if (!en_r[c])
            st_d[c] = S_RDN;
          else if (tgt_r[c] != lvl_q[c])
            st_d[c] = S_RAMP;
        end
        S_RDN: begin
          if (en_r[c])
            st_d[c] = S_RAMP;
          else if (lvl_q[c] == '0)
            st_d[c] = S_OFF;
          else if (&psc_q[c]) begin
            lvl_d[c] = lvl_q[c] - 1'b1;
            if (lvl_q[c] == LVL_W'(1))
              st_d[c] = S_OFF;
          end
        end
        default: begin
          st_d[c]  = S_OFF;
          lvl_d[c] = '0;
        end
      endcase
      psc_d[c] = ((st_d[c] == S_RAMP || st_d[c] == S_RDN) &&
                  st_d[c] != st_q[c]) ? '0 : psc_q[c] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        st_q[c]  <= S_OFF;
        lvl_q[c] <= '0;
        cnt_q[c] <= '0;
        psc_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        st_q[c]  <= st_d[c];
        lvl_q[c] <= lvl_d[c];
        cnt_q[c] <= cnt_d[c];
        psc_q[c] <= psc_d[c];
      end
    end
  end

  always_comb begin
    pd    = '0;
    mode  = '0;
    level = '0;
    busy  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      pd[c] = (st_q[c] == S_OFF);
      mode[c*MODE_W +: MODE_W] = mode_r[c];
      level[c*LVL_W +: LVL_W]  = lvl_q[c];
      busy = busy | (st_q[c] == S_WAKE) |
             (st_q[c] == S_RAMP) | (st_q[c] == S_RDN);
    end
  end

endmodule
